rf_xpr_wb_ctrl: RTL and testbench

- Write-side client of the 32x32 integer register file (2 write ports).
- Accepts results from two producers, buffers them, and drives the RF write ports wrt0/wrt1:
  - ch0: ALU/CSR.
  - ch1: load/long-latency unit.
  - A debug write port, which shares wrt0 with ch0.
- Keeps a per-register busy scoreboard that the issue stage uses to stall on RAW/WAW hazards.

---
 rtl/rf_xpr_pkg.sv | 23 ++
 rtl/rf_xpr_wb_fifo.sv | 75 +++++++
 rtl/rf_xpr_wb_ctrl.sv | 161 ++++++++++++++++
 tb/tb_rf_xpr_wb_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_xpr_pkg.sv
// -----------------------------------------------------------------------------
// rf_xpr_pkg
// Shared constants and types for the integer register file (XPR) write side.
//   XPR_AW   : register address width
//   XPR_DW   : register data width
//   XPR_SIZE : number of architectural registers
//   XPR_ZERO : address of the hard-wired zero register
//   xpr_wr_t : one register-file write request {WE, WA, D}
// -----------------------------------------------------------------------------
package rf_xpr_pkg;

  localparam int XPR_AW   = 5;
  localparam int XPR_DW   = 32;
  localparam int XPR_SIZE = 32;
  localparam logic [XPR_AW-1:0] XPR_ZERO = 5'd0;

  typedef struct packed {
    logic              WE;
    logic [XPR_AW-1:0] WA;
    logic [XPR_DW-1:0] D;
  } xpr_wr_t;

endpackage

// File: rtl/rf_xpr_wb_fifo.sv
// -----------------------------------------------------------------------------
// rf_xpr_wb_fifo
// Small synchronous result FIFO (circular buffer, pointers carry a wrap bit).
// Results addressed to x0 complete the handshake but are not stored.
// Ports:
//   CLK, RST          clock / asynchronous active-high reset
//   push_V/RA/D       incoming result
//   push_RDY          FIFO not full (from registered pointers only)
//   pop_EN            consume the head this cycle
//   head_V/RA/D       head entry (valid when FIFO non-empty)
// -----------------------------------------------------------------------------
module rf_xpr_wb_fifo
  import rf_xpr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = XPR_AW,
  parameter int DW    = XPR_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push_V,
  input  logic [AW-1:0] push_RA,
  input  logic [DW-1:0] push_D,
  output logic          push_RDY,
  input  logic          pop_EN,
  output logic          head_V,
  output logic [AW-1:0] head_RA,
  output logic [DW-1:0] head_D
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   wptr_r;
  logic [PW:0]   rptr_r;
  logic [AW-1:0] ra_mem_r [DEPTH];
  logic [DW-1:0] d_mem_r  [DEPTH];

  logic full_s;
  logic empty_s;
  logic wr_en_s;
  logic rd_en_s;

  // Full when only the wrap bits differ; empty when pointers are identical.
  assign full_s  = (wptr_r[PW] != rptr_r[PW]) && (wptr_r[PW-1:0] == rptr_r[PW-1:0]);
  assign empty_s = (wptr_r == rptr_r);

  assign push_RDY = !full_s;
  assign head_V   = !empty_s;
  assign head_RA  = ra_mem_r[rptr_r[PW-1:0]];
  assign head_D   = d_mem_r[rptr_r[PW-1:0]];

  // x0 results are acknowledged but dropped.
  assign wr_en_s = push_V && !full_s && (push_RA != {AW{1'b0}});
  assign rd_en_s = pop_EN && !empty_s;

  // Pointer update; reset discards any buffered entries.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr_r <= {(PW+1){1'b0}};
      rptr_r <= {(PW+1){1'b0}};
    end else begin
      if (wr_en_s) wptr_r <= wptr_r + {{PW{1'b0}}, 1'b1};
      if (rd_en_s) rptr_r <= rptr_r + {{PW{1'b0}}, 1'b1};
    end
  end

  // Entry storage; contents are meaningless until the write pointer passes them.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      ra_mem_r[wptr_r[PW-1:0]] <= push_RA;
      d_mem_r[wptr_r[PW-1:0]]  <= push_D;
    end
  end

endmodule

// File: rtl/rf_xpr_wb_ctrl.sv
// -----------------------------------------------------------------------------
// rf_xpr_wb_ctrl
// Write-side client of the 32x32 integer register file.
//   ch0 (ALU/CSR) and debug share write port wrt0, debug has priority.
//   ch1 (load/long-latency) owns write port wrt1.
//   A per-register busy scoreboard lets issue stall on RAW/WAW hazards.
// Ports:
//   CLK, RST                  clock / asynchronous active-high reset
//   iss_V, iss_RD, iss_RDY    issue-stage destination reservation
//   chk_RA0/1, chk_BUSY0/1    source-operand busy lookups
//   res0_*/res1_*             result channels (valid/ready, address, data)
//   dbg_V, dbg_WA, dbg_D      debug write (always accepted)
//   wrt0_*/wrt1_*             register-file write ports
//   err_DUP                   both ports writing the same address this cycle
//   busy_VEC                  full scoreboard for trace
// -----------------------------------------------------------------------------
module rf_xpr_wb_ctrl
  import rf_xpr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int AW    = XPR_AW,
  parameter int DW    = XPR_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          iss_V,
  input  logic [AW-1:0] iss_RD,
  output logic          iss_RDY,
  input  logic [AW-1:0] chk_RA0,
  input  logic [AW-1:0] chk_RA1,
  output logic          chk_BUSY0,
  output logic          chk_BUSY1,
  input  logic          res0_V,
  input  logic [AW-1:0] res0_RA,
  input  logic [DW-1:0] res0_D,
  output logic          res0_RDY,
  input  logic          res1_V,
  input  logic [AW-1:0] res1_RA,
  input  logic [DW-1:0] res1_D,
  output logic          res1_RDY,
  input  logic          dbg_V,
  input  logic [AW-1:0] dbg_WA,
  input  logic [DW-1:0] dbg_D,
  output logic          dbg_RDY,
  output logic          wrt0_WE,
  output logic [AW-1:0] wrt0_WA,
  output logic [DW-1:0] wrt0_D,
  output logic          wrt1_WE,
  output logic [AW-1:0] wrt1_WA,
  output logic [DW-1:0] wrt1_D,
  output logic          err_DUP,
  output logic [31:0]   busy_VEC
);

  localparam logic [XPR_SIZE-1:0] ONE_HOT0 = {{(XPR_SIZE-1){1'b0}}, 1'b1};

  logic          head0_v_s;
  logic [AW-1:0] head0_ra_s;
  logic [DW-1:0] head0_d_s;
  logic          head1_v_s;
  logic [AW-1:0] head1_ra_s;
  logic [DW-1:0] head1_d_s;
  logic          pop0_s;
  logic          pop1_s;

  xpr_wr_t wrt0_s;
  xpr_wr_t wrt1_s;

  logic [XPR_SIZE-1:0] busy_r;
  logic [XPR_SIZE-1:0] set_s;
  logic [XPR_SIZE-1:0] clr_s;
  logic [XPR_SIZE-1:0] busy_nxt_s;
  logic                iss_take_s;

  rf_xpr_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo0 (
    .CLK      (CLK),
    .RST      (RST),
    .push_V   (res0_V),
    .push_RA  (res0_RA),
    .push_D   (res0_D),
    .push_RDY (res0_RDY),
    .pop_EN   (pop0_s),
    .head_V   (head0_v_s),
    .head_RA  (head0_ra_s),
    .head_D   (head0_d_s)
  );

  rf_xpr_wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo1 (
    .CLK      (CLK),
    .RST      (RST),
    .push_V   (res1_V),
    .push_RA  (res1_RA),
    .push_D   (res1_D),
    .push_RDY (res1_RDY),
    .pop_EN   (pop1_s),
    .head_V   (head1_v_s),
    .head_RA  (head1_ra_s),
    .head_D   (head1_d_s)
  );

  assign dbg_RDY = 1'b1;

  // wrt0 mux: debug wins and holds the ch0 head; reset silences the debug path.
  always_comb begin
    wrt0_s = '0;
    pop0_s = 1'b0;
    if (dbg_V && !RST) begin
      wrt0_s.WE = 1'b1;
      wrt0_s.WA = dbg_WA;
      wrt0_s.D  = dbg_D;
      pop0_s    = 1'b0;
    end else begin
      wrt0_s.WE = head0_v_s;
      wrt0_s.WA = head0_ra_s;
      wrt0_s.D  = head0_d_s;
      pop0_s    = head0_v_s;
    end
  end

  // wrt1 is a straight drive of the ch1 head.
  always_comb begin
    wrt1_s    = '0;
    wrt1_s.WE = head1_v_s;
    wrt1_s.WA = head1_ra_s;
    wrt1_s.D  = head1_d_s;
    pop1_s    = head1_v_s;
  end

  assign wrt0_WE = wrt0_s.WE;
  assign wrt0_WA = wrt0_s.WA;
  assign wrt0_D  = wrt0_s.D;
  assign wrt1_WE = wrt1_s.WE;
  assign wrt1_WA = wrt1_s.WA;
  assign wrt1_D  = wrt1_s.D;

  // Covers ch0/ch1 and debug/ch1; the RF resolves in favour of wrt1.
  assign err_DUP = wrt0_s.WE && wrt1_s.WE && (wrt0_s.WA == wrt1_s.WA);

  assign iss_RDY    = !busy_r[iss_RD] || (iss_RD == XPR_ZERO);
  assign chk_BUSY0  = busy_r[chk_RA0] && (chk_RA0 != XPR_ZERO);
  assign chk_BUSY1  = busy_r[chk_RA1] && (chk_RA1 != XPR_ZERO);
  assign busy_VEC   = busy_r;

  // Only ch0/ch1 writes retire reservations; debug writes leave busy alone.
  assign iss_take_s = iss_V && iss_RDY && (iss_RD != XPR_ZERO);
  assign set_s      = iss_take_s ? (ONE_HOT0 << iss_RD) : {XPR_SIZE{1'b0}};
  assign clr_s      = (pop0_s ? (ONE_HOT0 << head0_ra_s) : {XPR_SIZE{1'b0}})
                    | (pop1_s ? (ONE_HOT0 << head1_ra_s) : {XPR_SIZE{1'b0}});
  // Set is applied after clear so it wins; x0 is forced clear.
  assign busy_nxt_s = ((busy_r & ~clr_s) | set_s) & ~ONE_HOT0;

  // Scoreboard register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      busy_r <= {XPR_SIZE{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: tb/tb_rf_xpr_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rf_xpr_wb_ctrl
// Directed self-checking bench for rf_xpr_wb_ctrl (DEPTH=2).
// Inputs change 1 time unit after a rising edge; outputs are compared 2 units
// after the edge, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_rf_xpr_wb_ctrl;

  logic        CLK;
  logic        RST;
  logic        iss_V;
  logic [4:0]  iss_RD;
  logic        iss_RDY;
  logic [4:0]  chk_RA0, chk_RA1;
  logic        chk_BUSY0, chk_BUSY1;
  logic        res0_V, res1_V;
  logic [4:0]  res0_RA, res1_RA;
  logic [31:0] res0_D, res1_D;
  logic        res0_RDY, res1_RDY;
  logic        dbg_V;
  logic [4:0]  dbg_WA;
  logic [31:0] dbg_D;
  logic        dbg_RDY;
  logic        wrt0_WE, wrt1_WE;
  logic [4:0]  wrt0_WA, wrt1_WA;
  logic [31:0] wrt0_D, wrt1_D;
  logic        err_DUP;
  logic [31:0] busy_VEC;

  int tests_run;
  int tests_failed;

  rf_xpr_wb_ctrl #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .CLK(CLK), .RST(RST),
    .iss_V(iss_V), .iss_RD(iss_RD), .iss_RDY(iss_RDY),
    .chk_RA0(chk_RA0), .chk_RA1(chk_RA1),
    .chk_BUSY0(chk_BUSY0), .chk_BUSY1(chk_BUSY1),
    .res0_V(res0_V), .res0_RA(res0_RA), .res0_D(res0_D), .res0_RDY(res0_RDY),
    .res1_V(res1_V), .res1_RA(res1_RA), .res1_D(res1_D), .res1_RDY(res1_RDY),
    .dbg_V(dbg_V), .dbg_WA(dbg_WA), .dbg_D(dbg_D), .dbg_RDY(dbg_RDY),
    .wrt0_WE(wrt0_WE), .wrt0_WA(wrt0_WA), .wrt0_D(wrt0_D),
    .wrt1_WE(wrt1_WE), .wrt1_WA(wrt1_WA), .wrt1_D(wrt1_D),
    .err_DUP(err_DUP), .busy_VEC(busy_VEC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    RST = 1'b1;
    iss_V = 1'b0; iss_RD = 5'd0;
    chk_RA0 = 5'd0; chk_RA1 = 5'd0;
    res0_V = 1'b0; res0_RA = 5'd0; res0_D = 32'd0;
    res1_V = 1'b0; res1_RA = 5'd0; res1_D = 32'd0;
    dbg_V = 1'b0; dbg_WA = 5'd0; dbg_D = 32'd0;

    // Reset state
    #2;
    check_val("rst_busy",  busy_VEC, 32'h0);
    check_val("rst_we0",   {31'd0, wrt0_WE}, 32'd0);
    check_val("rst_we1",   {31'd0, wrt1_WE}, 32'd0);
    check_val("rst_dup",   {31'd0, err_DUP}, 32'd0);
    check_val("rst_rdy0",  {31'd0, res0_RDY}, 32'd1);
    check_val("rst_rdy1",  {31'd0, res1_RDY}, 32'd1);
    check_val("rst_dbgrdy",{31'd0, dbg_RDY}, 32'd1);
    tick(); tick();
    RST = 1'b0;

    // Reserve x5
    iss_V = 1'b1; iss_RD = 5'd5;
    settle();
    check_val("iss_rdy_free", {31'd0, iss_RDY}, 32'd1);
    tick();
    iss_V = 1'b0; chk_RA0 = 5'd5; chk_RA1 = 5'd0;
    settle();
    check_val("busy_x5",     busy_VEC, 32'h0000_0020);
    check_val("iss_rdy_x5",  {31'd0, iss_RDY}, 32'd0);
    check_val("chk_busy0",   {31'd0, chk_BUSY0}, 32'd1);
    check_val("chk_busy1_x0",{31'd0, chk_BUSY1}, 32'd0);

    // ch0 result to x5, latency one edge
    res0_V = 1'b1; res0_RA = 5'd5; res0_D = 32'hDEAD_BEEF;
    tick();
    res0_V = 1'b0;
    settle();
    check_val("wb_we0", {31'd0, wrt0_WE}, 32'd1);
    check_val("wb_wa0", {27'd0, wrt0_WA}, 32'd5);
    check_val("wb_d0",  wrt0_D, 32'hDEAD_BEEF);
    check_val("wb_busy_pre", busy_VEC, 32'h0000_0020);
    tick();
    settle();
    check_val("wb_busy_post", busy_VEC, 32'h0);
    check_val("wb_we0_off",   {31'd0, wrt0_WE}, 32'd0);
    check_val("wb_chk_clear", {31'd0, chk_BUSY0}, 32'd0);

    // Debug holds wrt0 for 3 cycles while ch0 fills up
    dbg_V = 1'b1; dbg_WA = 5'd3; dbg_D = 32'h0000_00D0;
    res0_V = 1'b1; res0_RA = 5'd10; res0_D = 32'h0000_00A1;
    settle();
    check_val("dbg_c0_we", {31'd0, wrt0_WE}, 32'd1);
    check_val("dbg_c0_d",  wrt0_D, 32'h0000_00D0);
    tick();
    dbg_D = 32'h0000_00D1;
    res0_RA = 5'd11; res0_D = 32'h0000_00A2;
    settle();
    check_val("dbg_c1_wa", {27'd0, wrt0_WA}, 32'd3);
    check_val("dbg_c1_d",  wrt0_D, 32'h0000_00D1);
    check_val("dbg_c1_rdy", {31'd0, res0_RDY}, 32'd1);
    tick();
    dbg_D = 32'h0000_00D2;
    res0_RA = 5'd12; res0_D = 32'h0000_00A3;
    settle();
    check_val("dbg_full_rdy", {31'd0, res0_RDY}, 32'd0);
    check_val("dbg_c2_d",  wrt0_D, 32'h0000_00D2);
    tick();
    dbg_V = 1'b0; res0_V = 1'b0;
    settle();
    check_val("drain0_we", {31'd0, wrt0_WE}, 32'd1);
    check_val("drain0_wa", {27'd0, wrt0_WA}, 32'd10);
    check_val("drain0_d",  wrt0_D, 32'h0000_00A1);
    tick();
    settle();
    check_val("drain1_wa", {27'd0, wrt0_WA}, 32'd11);
    check_val("drain1_d",  wrt0_D, 32'h0000_00A2);
    check_val("drain1_rdy", {31'd0, res0_RDY}, 32'd1);
    tick();
    settle();
    check_val("drain_done", {31'd0, wrt0_WE}, 32'd0);

    // Collision ch0/ch1 on x7
    iss_V = 1'b1; iss_RD = 5'd7;
    tick();
    iss_V = 1'b0;
    settle();
    check_val("col_busy_pre", busy_VEC, 32'h0000_0080);
    res0_V = 1'b1; res0_RA = 5'd7; res0_D = 32'h0000_0011;
    res1_V = 1'b1; res1_RA = 5'd7; res1_D = 32'h0000_0022;
    tick();
    res0_V = 1'b0; res1_V = 1'b0;
    settle();
    check_val("col_dup",  {31'd0, err_DUP}, 32'd1);
    check_val("col_we",   {30'd0, wrt1_WE, wrt0_WE}, 32'd3);
    check_val("col_d1",   wrt1_D, 32'h0000_0022);
    check_val("col_d0",   wrt0_D, 32'h0000_0011);
    tick();
    settle();
    check_val("col_dup_off", {31'd0, err_DUP}, 32'd0);
    check_val("col_busy_post", busy_VEC, 32'h0);

    // Collision debug/ch1 on x9
    dbg_V = 1'b1; dbg_WA = 5'd9; dbg_D = 32'h0000_0099;
    res1_V = 1'b1; res1_RA = 5'd9; res1_D = 32'h0000_0033;
    tick();
    res1_V = 1'b0;
    settle();
    check_val("dcol_dup", {31'd0, err_DUP}, 32'd1);
    dbg_V = 1'b0;
    tick();
    settle();
    check_val("dcol_idle", {30'd0, wrt1_WE, wrt0_WE}, 32'd0);

    // ch1 result to x0: acknowledged, never written
    res1_V = 1'b1; res1_RA = 5'd0; res1_D = 32'h0000_1234;
    settle();
    check_val("x0_rdy", {31'd0, res1_RDY}, 32'd1);
    tick();
    res1_V = 1'b0;
    settle();
    check_val("x0_we1_a", {31'd0, wrt1_WE}, 32'd0);
    tick();
    settle();
    check_val("x0_we1_b", {31'd0, wrt1_WE}, 32'd0);
    check_val("x0_busy",  busy_VEC, 32'h0);

    // Reset mid-stream
    iss_V = 1'b1; iss_RD = 5'd7;
    tick();
    iss_RD = 5'd8;
    tick();
    iss_V = 1'b0;
    dbg_V = 1'b1; dbg_WA = 5'd1; dbg_D = 32'h0;
    res0_V = 1'b1; res0_RA = 5'd7; res0_D = 32'h0000_0077;
    tick();
    res0_RA = 5'd8; res0_D = 32'h0000_0088;
    tick();
    res0_V = 1'b0;
    settle();
    check_val("mid_busy",  busy_VEC, 32'h0000_0180);
    check_val("mid_full",  {31'd0, res0_RDY}, 32'd0);
    dbg_V = 1'b0; RST = 1'b1;
    settle();
    check_val("mrst_we0",  {31'd0, wrt0_WE}, 32'd0);
    check_val("mrst_busy", busy_VEC, 32'h0);
    check_val("mrst_rdy0", {31'd0, res0_RDY}, 32'd1);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("post_rst_we", {30'd0, wrt1_WE, wrt0_WE}, 32'd0);
      check_val("post_rst_busy", busy_VEC, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
